// File: rtl/adapter_block_fifo_2_axi_stream_pkt.sv
// +--------------------------------------------------------------------------+
// | adapter_block_fifo_2_axi_stream_pkt                                      |
// | Drains block-FIFO blocks onto a registered AXI Stream master, with       |
// | optional packetisation.                                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module adapter_block_fifo_2_axi_stream_pkt #(
  parameter int DATA_WIDTH  = 24,
  parameter int SIZE_WIDTH  = 24,
  parameter int USER_WIDTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_axi_clk,
  input  logic                   rst,
  input  logic                   i_block_fifo_rdy,
  output logic                   o_block_fifo_act,
  input  logic [SIZE_WIDTH-1:0]  i_block_fifo_size,
  input  logic [DATA_WIDTH:0]    i_block_fifo_data,
  output logic                   o_block_fifo_stb,
  input  logic [SIZE_WIDTH-1:0]  i_max_packet,
  input  logic                   i_axi_ready,
  output logic                   o_axi_valid,
  output logic [DATA_WIDTH-1:0]  o_axi_data,
  output logic                   o_axi_last,
  output logic [USER_WIDTH-1:0]  o_axi_user,
  output logic [COUNT_WIDTH-1:0] o_block_count
);

  localparam logic [SIZE_WIDTH:0]    C_ONE_S = {{SIZE_WIDTH{1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] C_ONE_C = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_DRAIN   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   act_q, act_d;
  logic [SIZE_WIDTH-1:0]  size_q, size_d;
  logic [SIZE_WIDTH-1:0]  max_q, max_d;
  logic [SIZE_WIDTH-1:0]  count_q, count_d;
  logic [SIZE_WIDTH-1:0]  pkt_q, pkt_d;
  logic                   sop_q, sop_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   last_q, last_d;
  logic [USER_WIDTH-1:0]  user_q, user_d;
  logic [COUNT_WIDTH-1:0] blk_q, blk_d;

  logic [SIZE_WIDTH:0] count_inc;
  logic [SIZE_WIDTH:0] pkt_inc;
  logic                final_beat;
  logic                pkt_end;
  logic                beat_last;
  logic                stb;

  // Increments are one bit wider so a maximal block size cannot wrap the compare.
  assign count_inc  = {1'b0, count_q} + C_ONE_S;
  assign pkt_inc    = {1'b0, pkt_q} + C_ONE_S;
  assign final_beat = (count_inc == {1'b0, size_q});
  assign pkt_end    = (max_q != '0) && (max_q < size_q) && (pkt_inc == {1'b0, max_q});
  assign beat_last  = final_beat || pkt_end;
  assign stb        = act_q && (state_q == S_ACTIVE) && (count_q < size_q) &&
                      (!valid_q || i_axi_ready);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    size_d  = size_q;
    max_d   = max_q;
    count_d = count_q;
    pkt_d   = pkt_q;
    sop_d   = sop_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    user_d  = user_q;
    blk_d   = blk_q;
    case (state_q)
      S_IDLE: begin
        if (i_block_fifo_rdy && !act_q) begin
          act_d   = 1'b1;
          size_d  = i_block_fifo_size;
          max_d   = i_max_packet;
          count_d = '0;
          pkt_d   = '0;
          sop_d   = 1'b1;
          state_d = (i_block_fifo_size == '0) ? S_RELEASE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (stb) begin
          data_d    = i_block_fifo_data[DATA_WIDTH-1:0];
          user_d    = '0;
          user_d[1] = sop_q;
          user_d[0] = i_block_fifo_data[DATA_WIDTH];
          last_d    = beat_last;
          valid_d   = 1'b1;
          count_d   = count_inc[SIZE_WIDTH-1:0];
          pkt_d     = beat_last ? '0 : pkt_inc[SIZE_WIDTH-1:0];
          sop_d     = beat_last;
          if (final_beat) begin
            state_d = S_DRAIN;
          end
        end else if (valid_q && i_axi_ready) begin
          valid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (!valid_q || i_axi_ready) begin
          valid_d = 1'b0;
          act_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        act_d   = 1'b0;
        blk_d   = blk_q + C_ONE_C;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      act_q   <= 1'b0;
      size_q  <= '0;
      max_q   <= '0;
      count_q <= '0;
      pkt_q   <= '0;
      sop_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      size_q  <= size_d;
      max_q   <= max_d;
      count_q <= count_d;
      pkt_q   <= pkt_d;
      sop_q   <= sop_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      user_q  <= user_d;
      blk_q   <= blk_d;
    end
  end

  assign o_block_fifo_act = act_q;
  assign o_block_fifo_stb = stb;
  assign o_axi_valid      = valid_q;
  assign o_axi_data       = data_q;
  assign o_axi_last       = last_q;
  assign o_axi_user       = user_q;
  assign o_block_count    = blk_q;

endmodule

`default_nettype wire

// File: tb/tb_adapter_block_fifo_2_axi_stream_pkt.sv
// +--------------------------------------------------------------------------+
// | tb_adapter_block_fifo_2_axi_stream_pkt                                   |
// | Directed self-checking bench for the block FIFO to AXIS adapter.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_adapter_block_fifo_2_axi_stream_pkt;

  localparam int DW = 24;
  localparam int SW = 24;
  localparam int UW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rdy;
  logic          fifo_act;
  logic [SW-1:0] fifo_size;
  logic [DW:0]   fifo_data;
  logic          fifo_stb;
  logic [SW-1:0] max_packet;
  logic          axi_ready = 1'b1;
  logic          axi_valid;
  logic [DW-1:0] axi_data;
  logic          axi_last;
  logic [UW-1:0] axi_user;
  logic [CW-1:0] block_count;

  adapter_block_fifo_2_axi_stream_pkt #(
    .DATA_WIDTH (DW),
    .SIZE_WIDTH (SW),
    .USER_WIDTH (UW),
    .COUNT_WIDTH(CW)
  ) u_dut (
    .i_axi_clk        (clk),
    .rst              (rst),
    .i_block_fifo_rdy (fifo_rdy),
    .o_block_fifo_act (fifo_act),
    .i_block_fifo_size(fifo_size),
    .i_block_fifo_data(fifo_data),
    .o_block_fifo_stb (fifo_stb),
    .i_max_packet     (max_packet),
    .i_axi_ready      (axi_ready),
    .o_axi_valid      (axi_valid),
    .o_axi_data       (axi_data),
    .o_axi_last       (axi_last),
    .o_axi_user       (axi_user),
    .o_block_count    (block_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO read-port model: head word is combinational, stb advances it.
  logic [DW:0] mem [0:255];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  base;
  assign fifo_data = mem[rd_ptr];

  initial forever begin
    @(posedge clk);
    if (fifo_stb && !rst) rd_ptr <= rd_ptr + 8'd1;
  end

  bit       pat_en = 1'b0;
  logic [5:0] pat  = 6'b011001;
  int       pidx   = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (pat_en) begin
      axi_ready = pat[pidx];
      pidx      = (pidx + 1) % 6;
    end else begin
      axi_ready = 1'b1;
    end
  end

  logic [DW-1:0] acc_d [$];
  logic          acc_l [$];
  logic [UW-1:0] acc_u [$];
  int            rise_q [$];
  int            fall_q [$];
  int            stb_n, val_n, act_n;
  int            cyc      = 0;
  bit            act_prev = 1'b0;
  bit            hold_prev = 1'b0;
  logic [63:0]   hold_val;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (hold_prev)
        chk("hold_stable", {34'd0, axi_valid, axi_last, axi_user, axi_data}, hold_val);
      hold_prev = axi_valid && !axi_ready;
      hold_val  = {34'd0, axi_valid, axi_last, axi_user, axi_data};
      if (axi_valid && axi_ready) begin
        acc_d.push_back(axi_data);
        acc_l.push_back(axi_last);
        acc_u.push_back(axi_user);
      end
      if (fifo_stb)  stb_n++;
      if (axi_valid) val_n++;
      if (fifo_act)  act_n++;
      if (fifo_act && !act_prev) rise_q.push_back(cyc);
      if (!fifo_act && act_prev) fall_q.push_back(cyc);
    end else begin
      hold_prev = 1'b0;
    end
    act_prev = fifo_act;
  end

  task automatic clear_stats();
    acc_d.delete();
    acc_l.delete();
    acc_u.delete();
    rise_q.delete();
    fall_q.delete();
    stb_n = 0;
    val_n = 0;
    act_n = 0;
  endtask

  task automatic load_words(input int n, input bit flag);
    logic [7:0] ix;
    for (int k = 0; k < n; k++) begin
      ix      = rd_ptr + 8'(k);
      mem[ix] = {flag, 24'h100000 + {16'h0, ix}};
    end
  endtask

  task automatic start_block(input int size, input int mx, input bit flag);
    int t;
    load_words(size, flag);
    base = rd_ptr;
    clear_stats();
    @(posedge clk);
    #1;
    fifo_size  = SW'(size);
    max_packet = SW'(mx);
    fifo_rdy   = 1'b1;
    t = 0;
    while (!fifo_act && t < 10) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!fifo_act) chk("act_rise_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    fifo_rdy   = 1'b0;
    // Latched values must win over later port changes.
    fifo_size  = 24'h00ABCD;
    max_packet = 24'd1;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (fifo_act && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (fifo_act) chk("act_fall_timeout", 64'd1, 64'd0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_beats(input int n, input bit flag, input logic [15:0] lm,
                             input logic [15:0] sm, input string t);
    logic [7:0] ix;
    chk({t, " beats"}, 64'(acc_d.size()), 64'(n));
    for (int k = 0; k < n && k < acc_d.size(); k++) begin
      ix = base + 8'(k);
      chk($sformatf("%s data%0d", t, k), 64'(acc_d[k]), 64'(24'h100000 + {16'h0, ix}));
      chk($sformatf("%s last%0d", t, k), 64'(acc_l[k]), 64'(lm[k]));
      chk($sformatf("%s user%0d", t, k), 64'(acc_u[k]), 64'({2'b00, sm[k], flag}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [7:0] ix;
    rst        = 1'b1;
    fifo_rdy   = 1'b0;
    fifo_size  = '0;
    max_packet = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", 64'(axi_valid), 64'd0);
    chk("rst act",   64'(fifo_act),  64'd0);
    chk("rst stb",   64'(fifo_stb),  64'd0);
    chk("rst last",  64'(axi_last),  64'd0);
    chk("rst user",  64'(axi_user),  64'd0);
    chk("rst data",  64'(axi_data),  64'd0);
    chk("rst count", 64'(block_count), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1) plain 4-beat block, sink always ready
    start_block(4, 0, 1'b0);
    wait_done();
    check_beats(4, 1'b0, 16'h0008, 16'h0001, "t1");
    chk("t1 stb_n", 64'(stb_n), 64'd4);
    chk("t1 val_n", 64'(val_n), 64'd4);
    chk("t1 count", 64'(block_count), 64'd1);

    // 2) backpressure pattern 1,0,0,1,1,0
    pat_en = 1'b1;
    start_block(6, 0, 1'b1);
    wait_done();
    pat_en = 1'b0;
    check_beats(6, 1'b1, 16'h0020, 16'h0001, "t2");
    chk("t2 stb_n", 64'(stb_n), 64'd6);
    chk("t2 count", 64'(block_count), 64'd2);

    // 3) packets of 3 beats within an 8-beat block
    start_block(8, 3, 1'b0);
    wait_done();
    check_beats(8, 1'b0, 16'h00A4, 16'h0049, "t3");
    chk("t3 count", 64'(block_count), 64'd3);

    // 4) empty block
    start_block(0, 0, 1'b0);
    wait_done();
    chk("t4 act_n", 64'(act_n), 64'd1);
    chk("t4 val_n", 64'(val_n), 64'd0);
    chk("t4 stb_n", 64'(stb_n), 64'd0);
    chk("t4 beats", 64'(acc_d.size()), 64'd0);
    chk("t4 count", 64'(block_count), 64'd4);

    // 5) reset mid-block after 5 accepted beats
    start_block(16, 0, 1'b0);
    t = 0;
    while (acc_d.size() < 5 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("t5 reach5", 64'(acc_d.size() >= 5), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5 valid", 64'(axi_valid), 64'd0);
    chk("t5 act",   64'(fifo_act),  64'd0);
    chk("t5 stb",   64'(fifo_stb),  64'd0);
    chk("t5 count", 64'(block_count), 64'd0);
    rst = 1'b0;
    chk("t5 beats", 64'(acc_d.size()), 64'd5);
    for (int k = 0; k < 5 && k < acc_d.size(); k++) begin
      ix = base + 8'(k);
      chk($sformatf("t5 data%0d", k), 64'(acc_d[k]), 64'(24'h100000 + {16'h0, ix}));
    end
    repeat (2) @(posedge clk);
    start_block(2, 0, 1'b1);
    wait_done();
    check_beats(2, 1'b1, 16'h0002, 16'h0001, "t5b");
    chk("t5b count", 64'(block_count), 64'd1);

    // 6) back-to-back single-beat blocks with flag set
    load_words(2, 1'b1);
    base = rd_ptr;
    clear_stats();
    @(posedge clk);
    #1;
    fifo_size  = 24'd1;
    max_packet = 24'd0;
    fifo_rdy   = 1'b1;
    t = 0;
    while (rise_q.size() < 2 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("t6 two_blocks", 64'(rise_q.size()), 64'd2);
    @(posedge clk);
    #1;
    fifo_rdy = 1'b0;
    wait_done();
    check_beats(2, 1'b1, 16'h0003, 16'h0003, "t6");
    if (rise_q.size() >= 2 && fall_q.size() >= 1)
      chk("t6 gap", 64'(rise_q[1] - fall_q[0]), 64'd2);
    else
      chk("t6 gap_events", 64'(fall_q.size()), 64'd1);
    chk("t6 count", 64'(block_count), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
